// File: rtl/truth_table_capture_pkg.sv
// Shared widths, FSM encoding and payload types for the truth-table capture block.
package truth_table_capture_pkg;

  localparam int unsigned IDX_W = 3;
  localparam int unsigned N_VEC = 8;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned ERR_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // One captured observation: applied vector index and the o seen for it.
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             o;
  } sample_t;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == {ERR_W{1'b1}}) ? v : v + ERR_W'(1);
  endfunction

endpackage

// File: rtl/truth_table_capture_settle_timer.sv
// Loadable down-counter; expire_c flags the last cycle of the settle window.
module truth_table_capture_settle_timer
  import truth_table_capture_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             expire_c
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign expire_c = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/truth_table_capture.sv
// Captures the 8-entry truth table of a 3-input combinational block via valid/ready,
// tracking coverage, mismatches against EXPECTED and unstable re-samples.
module truth_table_capture
  import truth_table_capture_pkg::*;
#(
  parameter int unsigned          SETTLE_CYC = 2,
  parameter logic [N_VEC-1:0]     EXPECTED   = 8'b1110_1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             o,
  output logic [N_VEC-1:0] table_o,
  output logic [N_VEC-1:0] covered,
  output logic             done,
  output logic             mismatch,
  output logic [IDX_W-1:0] err_idx,
  output logic [ERR_W-1:0] err_count,
  output logic             unstable
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [N_VEC-1:0]   table_q, table_d;
  logic [N_VEC-1:0]   cov_q, cov_d;
  logic               mis_q, mis_d;
  logic [IDX_W-1:0]   eidx_q, eidx_d;
  logic [ERR_W-1:0]   ecnt_q, ecnt_d;
  logic               unst_q, unst_d;
  logic               ready_q, ready_d;
  logic               transfer_c;
  logic               timer_load_c;
  logic               timer_dec_c;
  logic               expire_c;

  truth_table_capture_settle_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load_c),
    .load_val (CNT_W'(SETTLE_CYC)),
    .dec      (timer_dec_c),
    .expire_c (expire_c)
  );

  assign transfer_c = in_valid && ready_q;

  // Next-state and result update; clear overrides everything, dropping any transfer.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    table_d      = table_q;
    cov_d        = cov_q;
    mis_d        = mis_q;
    eidx_d       = eidx_q;
    ecnt_d       = ecnt_q;
    unst_d       = unst_q;
    timer_load_c = 1'b0;
    timer_dec_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (transfer_c) begin
          idx_d        = {a, b, c};
          timer_load_c = 1'b1;
          state_d      = (SETTLE_CYC == 0) ? ST_SAMPLE : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        timer_dec_c = 1'b1;
        if (expire_c) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (cov_q[idx_q] && (table_q[idx_q] != o)) unst_d = 1'b1;
        table_d[idx_q] = o;
        cov_d[idx_q]   = 1'b1;
        if (o != EXPECTED[idx_q]) begin
          mis_d  = 1'b1;
          ecnt_d = sat_inc(ecnt_q);
          if (!mis_q) eidx_d = idx_q;
        end
        state_d = (&cov_d) ? ST_DONE : ST_IDLE;
      end
      ST_DONE: ;
      default: state_d = ST_IDLE;
    endcase

    if (clear) begin
      state_d      = ST_IDLE;
      table_d      = '0;
      cov_d        = '0;
      mis_d        = 1'b0;
      eidx_d       = '0;
      ecnt_d       = '0;
      unst_d       = 1'b0;
      timer_load_c = 1'b0;
    end

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      table_q <= '0;
      cov_q   <= '0;
      mis_q   <= 1'b0;
      eidx_q  <= '0;
      ecnt_q  <= '0;
      unst_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      table_q <= table_d;
      cov_q   <= cov_d;
      mis_q   <= mis_d;
      eidx_q  <= eidx_d;
      ecnt_q  <= ecnt_d;
      unst_q  <= unst_d;
      ready_q <= ready_d;
    end
  end

  assign in_ready  = ready_q;
  assign table_o   = table_q;
  assign covered   = cov_q;
  assign done      = &cov_q;
  assign mismatch  = mis_q;
  assign err_idx   = eidx_q;
  assign err_count = ecnt_q;
  assign unstable  = unst_q;

endmodule

// File: tb/tb_truth_table_capture.sv
// Directed bench for truth_table_capture: scoreboard queue of applied samples plus a
// reference model of the table, coverage and error bookkeeping.
module tb_truth_table_capture;
  import truth_table_capture_pkg::*;

  localparam int unsigned SETTLE_CYC = 2;
  localparam logic [7:0]  EXP        = 8'b1110_1000;

  logic       clk = 1'b0;
  logic       rst_n, clear, in_valid, in_ready, a, b, c, o;
  logic [7:0] table_o, covered;
  logic       done, mismatch, unstable;
  logic [2:0] err_idx;
  logic [3:0] err_count;

  truth_table_capture #(.SETTLE_CYC(SETTLE_CYC), .EXPECTED(EXP)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .o(o), .table_o(table_o), .covered(covered), .done(done),
    .mismatch(mismatch), .err_idx(err_idx), .err_count(err_count), .unstable(unstable)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_cmp  = 0;
  int n_fail = 0;
  sample_t sb[$];

  logic [7:0] m_tab, m_cov;
  logic       m_mis, m_unst;
  logic [2:0] m_eidx;
  logic [3:0] m_ecnt;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_tab = '0; m_cov = '0; m_mis = 1'b0; m_unst = 1'b0; m_eidx = '0; m_ecnt = '0;
  endtask

  task automatic model_apply(input sample_t s);
    if (m_cov[s.idx] && (m_tab[s.idx] != s.o)) m_unst = 1'b1;
    m_tab[s.idx] = s.o;
    m_cov[s.idx] = 1'b1;
    if (s.o != EXP[s.idx]) begin
      if (!m_mis) m_eidx = s.idx;
      m_mis = 1'b1;
      if (m_ecnt != 4'hF) m_ecnt = m_ecnt + 4'd1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".table_o"},   table_o,   m_tab);
    chk({tag, ".covered"},   covered,   m_cov);
    chk({tag, ".done"},      8'(done),      8'(&m_cov));
    chk({tag, ".mismatch"},  8'(mismatch),  8'(m_mis));
    chk({tag, ".err_idx"},   8'(err_idx),   8'(m_eidx));
    chk({tag, ".err_count"}, 8'(err_count), 8'(m_ecnt));
    chk({tag, ".unstable"},  8'(unstable),  8'(m_unst));
    chk({tag, ".in_ready"},  8'(in_ready),  8'(!(&m_cov)));
  endtask

  // Drive one vector through the handshake and check the update lands SETTLE_CYC+1 edges later.
  task automatic send(input logic [2:0] idx, input logic ov);
    int n = 0;
    sample_t s;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk("ready_wait", 8'(in_ready), 8'd1);
    {a, b, c} = idx; o = ov; in_valid = 1'b1;
    sb.push_back('{idx: idx, o: ov});
    n_vec++;
    @(negedge clk);
    in_valid = 1'b0;
    chk("busy_ready", 8'(in_ready), 8'd0);
    repeat (SETTLE_CYC) @(negedge clk);
    if (!m_cov[idx]) chk("early_cov", 8'(covered[idx]), 8'd0);
    @(negedge clk);
    s = sb.pop_front();
    model_apply(s);
    check_all("upd");
  endtask

  task automatic sweep(input logic [2:0] bad, input logic inject);
    for (int i = 0; i < 8; i++) begin
      logic [2:0] ix;
      ix = 3'(i);
      send(ix, EXP[ix] ^ (inject && (ix == bad)));
    end
  endtask

  task automatic do_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    model_reset();
    check_all("clear");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; a = 0; b = 0; c = 0; o = 0;
    model_reset();
    #12;
    chk("rst.in_ready", 8'(in_ready), 8'd0);
    chk("rst.table_o", table_o, 8'h00);
    chk("rst.covered", covered, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check_all("post_rst");

    // 1: clean sweep
    sweep(3'd0, 1'b0);
    chk("t1.table_o", table_o, 8'hE8);
    chk("t1.done", 8'(done), 8'd1);
    @(negedge clk);
    chk("t1.hold_ready", 8'(in_ready), 8'd0);
    do_clear();

    // 2: vector 101 answers wrong
    sweep(3'd5, 1'b1);
    chk("t2.err_idx", 8'(err_idx), 8'd5);
    chk("t2.err_count", 8'(err_count), 8'd1);
    chk("t2.table_o", table_o, 8'hC8);
    do_clear();

    // 3: unstable re-sample of 010
    send(3'd2, 1'b0);
    send(3'd2, 1'b1);
    chk("t3.unstable", 8'(unstable), 8'd1);
    chk("t3.covered", covered, 8'h04);

    // 4: clear coincident with a transfer of 111
    @(negedge clk);
    {a, b, c} = 3'd7; o = 1'b1; in_valid = 1'b1; clear = 1'b1; n_vec++;
    @(negedge clk);
    in_valid = 1'b0; clear = 1'b0;
    model_reset();
    check_all("t4");
    repeat (SETTLE_CYC + 2) @(negedge clk);
    check_all("t4.later");

    // 5: reset during SETTLE of 011
    send(3'd2, 1'b0);
    @(negedge clk);
    {a, b, c} = 3'd3; o = 1'b1; in_valid = 1'b1; n_vec++;
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t5.covered", covered, 8'h00);
    chk("t5.table_o", table_o, 8'h00);
    chk("t5.in_ready", 8'(in_ready), 8'd0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check_all("t5.release");
    repeat (SETTLE_CYC + 2) @(negedge clk);
    check_all("t5.later");

    // 6: twenty wrong samples, first bad index 3, saturating count
    for (int i = 0; i < 20; i++) begin
      logic [2:0] ix;
      ix = (i < 12) ? ((i % 2 == 1) ? 3'd6 : 3'd3) : 3'(i - 12);
      if (i == 19) chk("t6.not_done", 8'(done), 8'd0);
      send(ix, ~EXP[ix]);
    end
    chk("t6.err_count", 8'(err_count), 8'd15);
    chk("t6.err_idx", 8'(err_idx), 8'd3);
    chk("t6.done", 8'(done), 8'd1);
    chk("t6.in_ready", 8'(in_ready), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
